// File: rtl/bp_me_pkg.sv
// BedRock memory header layout and the bank-select helper used by the memory-bank splitter.
// Build option BP_MEM_BANK_HASH_EN folds the next-higher address field into the bank select.
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0
  } bp_params_e;

  localparam int paddr_width_gp   = 40;
  localparam int bank_id_width_gp = 3;
  localparam int hdr_addr_lsb_gp  = 8;

  typedef struct packed {
    logic [7:0]                payload;
    logic [2:0]                size;
    logic [paddr_width_gp-1:0] addr;
    logic [3:0]                subop;
    logic [3:0]                msg_type;
  } bp_bedrock_mem_header_s;

  function automatic int bp_paddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return paddr_width_gp;
      default:          return paddr_width_gp;
    endcase
  endfunction

  // num_banks is a power of two, so the mask is the low lg(num_banks) bits.
  function automatic logic [bank_id_width_gp-1:0] bp_bank_select(
    input logic [paddr_width_gp-1:0] addr,
    input int                        num_banks,
    input int                        offset
  );
    logic [paddr_width_gp-1:0] mask;
    logic [paddr_width_gp-1:0] sel;
    mask = paddr_width_gp'(num_banks - 1);
    sel  = (addr >> offset) & mask;
`ifdef BP_MEM_BANK_HASH_EN
    begin
      int lg;
      lg = 0;
      for (int i = 1; i < 4; i++) begin
        if ((1 << i) == num_banks) lg = i;
      end
      sel = sel ^ ((addr >> (offset + lg)) & mask);
    end
`endif
    return sel[bank_id_width_gp-1:0];
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small 1-read/1-write FIFO holding bank IDs of outstanding commands.
// Pointers wrap modulo els_p, so the depth need not be a power of two.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 2,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp = $clog2(els_p + 1);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] wptr_r, rptr_r;
  logic [cnt_width_lp-1:0] count_r;
  logic                    push, pop;

  function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full blocks a push even when a pop lands in the same cycle.
  assign ready_o = (count_r != cnt_width_lp'(els_p));
  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) wptr_r <= next_ptr(wptr_r);
      if (pop)  rptr_r <= next_ptr(rptr_r);
      count_r <= count_r + cnt_width_lp'(push) - cnt_width_lp'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_me_mem_bank_splitter.sv
// Splits one BedRock memory command stream across num_banks_p banks and merges responses in order.
// Build option BP_MEM_BANK_HASH_EN selects the XOR-folded bank hash (see bp_me_pkg).
module bp_me_mem_bank_splitter
  import bp_me_pkg::*;
#(
  parameter bp_params_e bp_params_p   = e_bp_default_cfg,
  parameter int         num_banks_p   = 4,
  parameter int         bank_offset_p = 6,
  parameter int         data_width_p  = 64,
  parameter int         outstanding_p = 8,
  localparam int        hdr_width_lp  = $bits(bp_bedrock_mem_header_s)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,

  input  logic [hdr_width_lp-1:0]              mem_cmd_header_i,
  input  logic [data_width_p-1:0]              mem_cmd_data_i,
  input  logic                                 mem_cmd_v_i,
  output logic                                 mem_cmd_ready_and_o,
  input  logic                                 mem_cmd_last_i,

  output logic [hdr_width_lp-1:0]              mem_resp_header_o,
  output logic [data_width_p-1:0]              mem_resp_data_o,
  output logic                                 mem_resp_v_o,
  input  logic                                 mem_resp_yumi_i,
  output logic                                 mem_resp_last_o,

  output logic [num_banks_p*hdr_width_lp-1:0]  bank_cmd_header_o,
  output logic [num_banks_p*data_width_p-1:0]  bank_cmd_data_o,
  output logic [num_banks_p-1:0]               bank_cmd_v_o,
  input  logic [num_banks_p-1:0]               bank_cmd_ready_and_i,
  output logic [num_banks_p-1:0]               bank_cmd_last_o,

  input  logic [num_banks_p*hdr_width_lp-1:0]  bank_resp_header_i,
  input  logic [num_banks_p*data_width_p-1:0]  bank_resp_data_i,
  input  logic [num_banks_p-1:0]               bank_resp_v_i,
  output logic [num_banks_p-1:0]               bank_resp_yumi_o,
  input  logic [num_banks_p-1:0]               bank_resp_last_i
);

  localparam int paddr_width_lp = bp_paddr_width(bp_params_p);
  localparam int lg_banks_lp    = (num_banks_p > 1) ? $clog2(num_banks_p) : 1;

  logic [paddr_width_lp-1:0] cmd_addr;
  logic [lg_banks_lp-1:0]    bank_new, bank_cur, head;
  logic                      lock_r;
  logic [lg_banks_lp-1:0]    lock_bank_r;
  logic                      fifo_ready, fifo_v;
  logic                      cmd_open, resp_open;
  logic                      cmd_accept, push, pop;

  assign cmd_addr = mem_cmd_header_i[hdr_addr_lsb_gp +: paddr_width_lp];
  assign bank_new = lg_banks_lp'(bp_bank_select(paddr_width_gp'(cmd_addr), num_banks_p, bank_offset_p));

  // Once a first beat is taken, the rest of the message follows the latched bank.
  assign bank_cur = lock_r ? lock_bank_r : bank_new;

  // Mid-message beats need no FIFO slot; a new first beat does.
  assign cmd_open            = ~reset_i & (lock_r | fifo_ready);
  assign mem_cmd_ready_and_o = cmd_open & bank_cmd_ready_and_i[bank_cur];
  assign cmd_accept          = mem_cmd_v_i & mem_cmd_ready_and_o;
  assign push                = cmd_accept & ~lock_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_r      <= 1'b0;
      lock_bank_r <= '0;
    end else if (cmd_accept) begin
      lock_r      <= ~mem_cmd_last_i;
      lock_bank_r <= bank_cur;
    end
  end

  bsg_fifo_1r1w_small #(
    .width_p (lg_banks_lp),
    .els_p   (outstanding_p)
  ) order_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (bank_cur),
    .v_i     (push),
    .ready_o (fifo_ready),
    .data_o  (head),
    .v_o     (fifo_v),
    .yumi_i  (pop)
  );

  assign resp_open         = ~reset_i & fifo_v;
  assign mem_resp_v_o      = resp_open & bank_resp_v_i[head];
  assign mem_resp_last_o   = bank_resp_last_i[head];
  assign mem_resp_header_o = bank_resp_header_i[head*hdr_width_lp +: hdr_width_lp];
  assign mem_resp_data_o   = bank_resp_data_i[head*data_width_p +: data_width_p];
  assign pop               = resp_open & mem_resp_yumi_i & bank_resp_last_i[head];

  for (genvar b = 0; b < num_banks_p; b++) begin : g_bank
    assign bank_cmd_header_o[b*hdr_width_lp +: hdr_width_lp] = mem_cmd_header_i;
    assign bank_cmd_data_o[b*data_width_p +: data_width_p]   = mem_cmd_data_i;
    assign bank_cmd_last_o[b]  = mem_cmd_last_i;
    assign bank_cmd_v_o[b]     = mem_cmd_v_i & cmd_open & (bank_cur == lg_banks_lp'(b));
    assign bank_resp_yumi_o[b] = resp_open & mem_resp_yumi_i & (head == lg_banks_lp'(b));
  end

endmodule
